alu_req_scheduler: RTL and testbench

- Shares one combinational 4-bit ALU (AND/OR/ADD/SUB/XOR/NOT/INC/DEC, 3-bit opcode, result/carry_out/zero_flag) between two requesters.
- Each requester uses a valid/ready handshake to request an operation.
- The block arbitrates between requests, registers operands, drives the ALU, captures its outputs and returns a tagged response.
- One operation is in flight at a time; the block sits between the request sources and the ALU instance.

---
 rtl/alu_req_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_alu_req_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: shares one combinational 4-bit ALU between two
// valid/ready requesters. It accepts one operation at a time, registers the
// operands towards the ALU, captures the ALU outputs one cycle later and holds
// a tagged response until the consumer takes it.
// FIXED_PRIO = 0 gives round-robin arbitration; FIXED_PRIO = 1 lets requester 0
// win every simultaneous request.
// Optional build macro ALU_REQ_SCHEDULER_STATS_EN adds saturating per-requester
// grant counters on ports gnt_cnt0 / gnt_cnt1.
module alu_req_scheduler #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       busy
`ifdef ALU_REQ_SCHEDULER_STATS_EN
    ,
    output logic [7:0] gnt_cnt0,
    output logic [7:0] gnt_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_id_q, rsp_id_d;
    logic [3:0] rsp_result_q, rsp_result_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_zero_q, rsp_zero_d;
    logic       last_grant_q, last_grant_d;

    logic       any_valid;
    logic       grant;
    logic       accept;

    // Combinational grant: a lone requester wins; a tie goes to the requester
    // that did not win last time, or always to requester 0 under fixed priority.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant     = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        accept     = (state_q == IDLE) && any_valid;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
    end

    // Next-state and datapath register updates for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_a_d      = grant ? req1_a  : req0_a;
                    alu_b_d      = grant ? req1_b  : req0_b;
                    alu_op_d     = grant ? req1_op : req0_op;
                    rsp_id_d     = grant;
                    last_grant_d = grant;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // ALU inputs have been stable from the registers all cycle.
                rsp_result_d = alu_result;
                rsp_carry_d  = alu_carry;
                rsp_zero_d   = alu_zero;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                // Returning to IDLE here means the earliest new acceptance is
                // the cycle after the response is consumed.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_a_q      <= 4'h0;
            alu_b_q      <= 4'h0;
            alu_op_q     <= 3'b000;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 4'h0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;
    assign busy       = (state_q != IDLE);

`ifdef ALU_REQ_SCHEDULER_STATS_EN
    logic [7:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [7:0] gnt_cnt1_q, gnt_cnt1_d;

    // Saturating acceptance counters; observation only, never fed back.
    always_comb begin
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        if (req0_ready && (gnt_cnt0_q != 8'hFF)) begin
            gnt_cnt0_d = gnt_cnt0_q + 8'd1;
        end
        if (req1_ready && (gnt_cnt1_q != 8'hFF)) begin
            gnt_cnt1_d = gnt_cnt1_q + 8'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0_q <= 8'h00;
            gnt_cnt1_q <= 8'h00;
        end else begin
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Testbench for alu_req_scheduler: a round-robin instance and a fixed-priority
// instance share the same stimulus, each driving its own behavioural ALU.
module tb_alu_req_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0] req0_a = 4'h0, req0_b = 4'h0, req1_a = 4'h0, req1_b = 4'h0;
    logic [2:0] req0_op = 3'b000, req1_op = 3'b000;
    logic       rsp_ready = 1'b0;

    // round-robin instance
    logic       req0_ready, req1_ready;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_opcode;
    logic       alu_carry, alu_zero;
    logic       rsp_valid, rsp_id, rsp_carry, rsp_zero, busy;
    logic [3:0] rsp_result;

    // fixed-priority instance
    logic       fp_req0_ready, fp_req1_ready;
    logic [3:0] fp_alu_a, fp_alu_b, fp_alu_result;
    logic [2:0] fp_alu_opcode;
    logic       fp_alu_carry, fp_alu_zero;
    logic       fp_rsp_valid, fp_rsp_id, fp_rsp_carry, fp_rsp_zero, fp_busy;
    logic [3:0] fp_rsp_result;

`ifdef ALU_REQ_SCHEDULER_STATS_EN
    logic [7:0] gnt_cnt0, gnt_cnt1, fp_gnt_cnt0, fp_gnt_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_req_scheduler #(.FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .busy(busy)
`ifdef ALU_REQ_SCHEDULER_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    alu_req_scheduler #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_opcode(fp_alu_opcode),
        .alu_result(fp_alu_result), .alu_carry(fp_alu_carry), .alu_zero(fp_alu_zero),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
        .rsp_result(fp_rsp_result), .rsp_carry(fp_rsp_carry), .rsp_zero(fp_rsp_zero),
        .busy(fp_busy)
`ifdef ALU_REQ_SCHEDULER_STATS_EN
        , .gnt_cnt0(fp_gnt_cnt0), .gnt_cnt1(fp_gnt_cnt1)
`endif
    );

    // Behavioural 4-bit ALU: {carry, zero, result}; only ADD produces carry.
    function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        logic [4:0] s;
        logic [3:0] r;
        logic       c;
        c = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; end
            3'b011: r = a - b;
            3'b100: r = a ^ b;
            3'b101: r = ~a;
            3'b110: r = a + 4'd1;
            default: r = a - 4'd1;
        endcase
        return {c, (r == 4'h0), r};
    endfunction

    always_comb {alu_carry, alu_zero, alu_result} = alu_f(alu_a, alu_b, alu_opcode);
    always_comb {fp_alu_carry, fp_alu_zero, fp_alu_result} = alu_f(fp_alu_a, fp_alu_b, fp_alu_opcode);

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    typedef struct packed {
        logic       rst;
        logic       v0;
        logic [3:0] a0;
        logic [3:0] b0;
        logic [2:0] op0;
        logic       v1;
        logic [3:0] a1;
        logic [3:0] b1;
        logic [2:0] op1;
        logic       rr;
        logic       e_r0;
        logic       e_r1;
        logic       e_vld;
        logic       e_id;
        logic [3:0] e_res;
        logic       e_cy;
        logic       e_zr;
        logic       e_busy;
        logic       e_fp0;
        logic       e_fp1;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                           input logic [2:0] op0, input logic v1, input logic [3:0] a1,
                           input logic [3:0] b1, input logic [2:0] op1);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000);
        step();
        rst = 1'b0;
    endtask

    initial begin
        // rst  v0 a0   b0   op0     v1 a1   b1   op1     rr | r0 r1 vld id res  cy zr busy fp0 fp1
        vecs[0]  = '{1'b1, 1'b0,4'h0,4'h0,3'b000, 1'b0,4'h0,4'h0,3'b000, 1'b0, 1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b0,1'b0};
        // single ADD F+1 from requester 0
        vecs[1]  = '{1'b0, 1'b1,4'hF,4'h1,3'b010, 1'b0,4'h0,4'h0,3'b000, 1'b1, 1'b1,1'b0,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b1,1'b0};
        vecs[2]  = '{1'b0, 1'b0,4'h0,4'h0,3'b000, 1'b0,4'h0,4'h0,3'b000, 1'b1, 1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[3]  = '{1'b0, 1'b0,4'h0,4'h0,3'b000, 1'b0,4'h0,4'h0,3'b000, 1'b1, 1'b0,1'b0,1'b1,1'b0,4'h0,1'b1,1'b1,1'b1,1'b0,1'b0};
        vecs[4]  = '{1'b1, 1'b0,4'h0,4'h0,3'b000, 1'b0,4'h0,4'h0,3'b000, 1'b1, 1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b0,1'b0};
        // both valid: req0 SUB 5-3, req1 XOR 9^9
        vecs[5]  = '{1'b0, 1'b1,4'h5,4'h3,3'b011, 1'b1,4'h9,4'h9,3'b100, 1'b1, 1'b1,1'b0,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b1,1'b0};
        vecs[6]  = '{1'b0, 1'b1,4'h5,4'h3,3'b011, 1'b1,4'h9,4'h9,3'b100, 1'b1, 1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[7]  = '{1'b0, 1'b1,4'h5,4'h3,3'b011, 1'b1,4'h9,4'h9,3'b100, 1'b1, 1'b0,1'b0,1'b1,1'b0,4'h2,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[8]  = '{1'b0, 1'b1,4'h5,4'h3,3'b011, 1'b1,4'h9,4'h9,3'b100, 1'b1, 1'b0,1'b1,1'b0,1'b0,4'h2,1'b0,1'b0,1'b0,1'b1,1'b0};
        vecs[9]  = '{1'b0, 1'b1,4'h5,4'h3,3'b011, 1'b1,4'h9,4'h9,3'b100, 1'b1, 1'b0,1'b0,1'b0,1'b1,4'h2,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[10] = '{1'b0, 1'b1,4'h5,4'h3,3'b011, 1'b1,4'h9,4'h9,3'b100, 1'b1, 1'b0,1'b0,1'b1,1'b1,4'h0,1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[11] = '{1'b0, 1'b1,4'h5,4'h3,3'b011, 1'b1,4'h9,4'h9,3'b100, 1'b1, 1'b1,1'b0,1'b0,1'b1,4'h0,1'b0,1'b1,1'b0,1'b1,1'b0};
        vecs[12] = '{1'b0, 1'b1,4'h5,4'h3,3'b011, 1'b1,4'h9,4'h9,3'b100, 1'b1, 1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[13] = '{1'b0, 1'b1,4'h5,4'h3,3'b011, 1'b1,4'h9,4'h9,3'b100, 1'b1, 1'b0,1'b0,1'b1,1'b0,4'h2,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[14] = '{1'b0, 1'b1,4'h5,4'h3,3'b011, 1'b1,4'h9,4'h9,3'b100, 1'b1, 1'b0,1'b1,1'b0,1'b0,4'h2,1'b0,1'b0,1'b0,1'b1,1'b0};

        step();

        // Table: apply inputs, let combinational outputs settle, compare, clock.
        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst;
            set_req(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].op0,
                    vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].op1);
            rsp_ready = vecs[i].rr;
            #1;
            chk("req0_ready", i, {7'd0, req0_ready}, {7'd0, vecs[i].e_r0});
            chk("req1_ready", i, {7'd0, req1_ready}, {7'd0, vecs[i].e_r1});
            chk("rsp_valid", i, {7'd0, rsp_valid}, {7'd0, vecs[i].e_vld});
            chk("rsp_id", i, {7'd0, rsp_id}, {7'd0, vecs[i].e_id});
            chk("rsp_result", i, {4'd0, rsp_result}, {4'd0, vecs[i].e_res});
            chk("rsp_carry", i, {7'd0, rsp_carry}, {7'd0, vecs[i].e_cy});
            chk("rsp_zero", i, {7'd0, rsp_zero}, {7'd0, vecs[i].e_zr});
            chk("busy", i, {7'd0, busy}, {7'd0, vecs[i].e_busy});
            chk("fp_req0_ready", i, {7'd0, fp_req0_ready}, {7'd0, vecs[i].e_fp0});
            chk("fp_req1_ready", i, {7'd0, fp_req1_ready}, {7'd0, vecs[i].e_fp1});
            step();
        end

        // Backpressure: response held for 5 cycles while requester 1 waits.
        do_reset();
        rsp_ready = 1'b0;
        set_req(1'b1, 4'hC, 4'hA, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000);
        #1;
        chk("bp_accept0", 0, {7'd0, req0_ready}, 8'd1);
        step();
        set_req(1'b1, 4'hC, 4'hA, 3'b000, 1'b1, 4'h3, 4'h4, 3'b010);
        #1;
        chk("bp_exec_r1rdy", 0, {7'd0, req1_ready}, 8'd0);
        chk("bp_alu_a", 0, {4'd0, alu_a}, 8'h0C);
        chk("bp_alu_b", 0, {4'd0, alu_b}, 8'h0A);
        chk("bp_alu_op", 0, {5'd0, alu_opcode}, 8'h00);
        step();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_rsp_valid", c, {7'd0, rsp_valid}, 8'd1);
            chk("bp_rsp_id", c, {7'd0, rsp_id}, 8'd0);
            chk("bp_rsp_result", c, {4'd0, rsp_result}, 8'h08);
            chk("bp_rsp_flags", c, {6'd0, rsp_carry, rsp_zero}, 8'd0);
            chk("bp_r1rdy", c, {7'd0, req1_ready}, 8'd0);
            chk("bp_busy", c, {7'd0, busy}, 8'd1);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_consume_vld", 0, {7'd0, rsp_valid}, 8'd1);
        chk("bp_consume_r1rdy", 0, {7'd0, req1_ready}, 8'd0);
        step();
        #1;
        chk("bp_idle_vld", 0, {7'd0, rsp_valid}, 8'd0);
        chk("bp_idle_busy", 0, {7'd0, busy}, 8'd0);
        chk("bp_idle_r1rdy", 0, {7'd0, req1_ready}, 8'd1);
        chk("bp_idle_r0rdy", 0, {7'd0, req0_ready}, 8'd0);
        chk("bp_idle_alu_a_hold", 0, {4'd0, alu_a}, 8'h0C);
        step();
        set_req(1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000);
        #1;
        chk("bp_r1_id", 0, {7'd0, rsp_id}, 8'd1);
        chk("bp_r1_alu_a", 0, {4'd0, alu_a}, 8'h03);
        step();
        #1;
        chk("bp_r1_result", 0, {4'd0, rsp_result}, 8'h07);
        chk("bp_r1_valid", 0, {7'd0, rsp_valid}, 8'd1);
        step();

        // Reset during EXEC: everything returns to reset values at once.
        set_req(1'b1, 4'hC, 4'hA, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000);
        #1;
        chk("mr_accept0", 0, {7'd0, req0_ready}, 8'd1);
        step();
        set_req(1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000);
        #1;
        chk("mr_exec_busy", 0, {7'd0, busy}, 8'd1);
        rst = 1'b1;
        #1;
        chk("mr_rsp_valid", 0, {7'd0, rsp_valid}, 8'd0);
        chk("mr_busy", 0, {7'd0, busy}, 8'd0);
        chk("mr_alu_a", 0, {4'd0, alu_a}, 8'd0);
        chk("mr_alu_b", 0, {4'd0, alu_b}, 8'd0);
        chk("mr_alu_op", 0, {5'd0, alu_opcode}, 8'd0);
        chk("mr_rsp_result", 0, {4'd0, rsp_result}, 8'd0);
        step();
        rst = 1'b0;
        set_req(1'b1, 4'h1, 4'h1, 3'b010, 1'b1, 4'h2, 4'h2, 3'b010);
        #1;
        chk("mr_first_r0rdy", 0, {7'd0, req0_ready}, 8'd1);
        chk("mr_first_r1rdy", 0, {7'd0, req1_ready}, 8'd0);
        step();
        set_req(1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000);
        step();
        step();

`ifdef ALU_REQ_SCHEDULER_STATS_EN
        // 300 back-to-back requester-0 operations saturate its counter.
        do_reset();
        rsp_ready = 1'b1;
        set_req(1'b1, 4'h1, 4'h2, 3'b001, 1'b0, 4'h0, 4'h0, 3'b000);
        repeat (900) step();
        set_req(1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000);
        repeat (3) step();
        chk("gnt_cnt0_sat", 0, gnt_cnt0, 8'd255);
        chk("gnt_cnt1_zero", 0, gnt_cnt1, 8'd0);
        chk("fp_gnt_cnt0_sat", 0, fp_gnt_cnt0, 8'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
